// File: rtl/musa_arb_pkg.sv
// Shared select codes, arbiter state type and index-to-select helper.
// Optional burst lock (HOLD_RELOAD state) is built with MUSA_ARB_LOCK_EN.
package musa_arb_pkg;

    localparam logic [2:0] SEL_REQ0 = 3'b000;
    localparam logic [2:0] SEL_REQ1 = 3'b001;
    localparam logic [2:0] SEL_REQ2 = 3'b010;
    localparam logic [2:0] SEL_REQ3 = 3'b100;
    localparam logic [2:0] SEL_REQ4 = 3'b101;
    localparam logic [2:0] SEL_REQ5 = 3'b110;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
`ifdef MUSA_ARB_LOCK_EN
        HOLD_RELOAD = 2'd2,
`endif
        HOLD        = 2'd1
    } arb_state_t;

    // Codes 011 and 111 are never produced by the mux decoder.
    function automatic logic [2:0] idx_to_sel(input logic [2:0] idx);
        logic [2:0] s;
        case (idx)
            3'd0:    s = SEL_REQ0;
            3'd1:    s = SEL_REQ1;
            3'd2:    s = SEL_REQ2;
            3'd3:    s = SEL_REQ3;
            3'd4:    s = SEL_REQ4;
            3'd5:    s = SEL_REQ5;
            default: s = SEL_REQ0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rr_pick6.sv
// Six-way rotating priority picker: first set request at or above ptr,
// wrapping past requester 5 back to requester 0.
module rr_pick6 (
    input  logic [5:0] req,
    input  logic [2:0] ptr,
    output logic [2:0] winner,
    output logic       any
);

    logic [3:0] pos;

    // Scan from the far end so the nearest hit to ptr is written last.
    always_comb begin
        winner = 3'd0;
        any    = 1'b0;
        pos    = 4'd0;
        for (int k = 5; k >= 0; k--) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'd6) pos = pos - 4'd6;
            if (req[pos[2:0]]) begin
                winner = pos[2:0];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux18_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 6-input 18-bit select mux.
// Define MUSA_ARB_LOCK_EN to add the lock port and burst reload.
module mux18_rr_arbiter
    import musa_arb_pkg::*;
#(
    parameter int DATA_W  = 18,
    parameter int NREQ    = 6,
    parameter int PTR_RST = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] data_flat,
    input  logic                   out_ready,
`ifdef MUSA_ARB_LOCK_EN
    input  logic [NREQ-1:0]        lock,
`endif
    output logic [NREQ-1:0]        grant,
    output logic [2:0]             sel,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    output logic [NREQ-1:0]        ack
);

    localparam logic [NREQ-1:0] ONE  = NREQ'(1);
    localparam logic [2:0]      LAST = 3'(NREQ - 1);

    arb_state_t          state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          own_q, own_d;
    logic [NREQ-1:0]     grant_d, ack_d;
    logic [2:0]          sel_d;
    logic [DATA_W-1:0]   data_d;
    logic                valid_d;
    logic [2:0]          pick;
    logic                any;
    logic                relock;
    logic [DATA_W-1:0]   words [8];

    for (genvar i = 0; i < 8; i++) begin : g_words
        if (i < NREQ) begin : g_in
            assign words[i] = data_flat[i*DATA_W +: DATA_W];
        end else begin : g_pad
            assign words[i] = '0;
        end
    end

    rr_pick6 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick),
        .any    (any)
    );

`ifdef MUSA_ARB_LOCK_EN
    assign relock = lock[own_q] && req[own_q];
`else
    assign relock = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        grant_d = grant;
        sel_d   = sel;
        data_d  = out_data;
        valid_d = out_valid;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    own_d   = pick;
                    grant_d = ONE << pick;
                    sel_d   = idx_to_sel(pick);
                    data_d  = words[pick];
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    ack_d   = ONE << own_q;
                    valid_d = 1'b0;
                    if (relock) begin
`ifdef MUSA_ARB_LOCK_EN
                        state_d = HOLD_RELOAD;
`endif
                    end else begin
                        grant_d = '0;
                        sel_d   = 3'b000;
                        data_d  = '0;
                        ptr_d   = (own_q == LAST) ? 3'd0 : own_q + 3'd1;
                        state_d = IDLE;
                    end
                end
            end
`ifdef MUSA_ARB_LOCK_EN
            // Same owner keeps the path; pick up its next word.
            HOLD_RELOAD: begin
                data_d  = words[own_q];
                valid_d = 1'b1;
                state_d = HOLD;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'(PTR_RST);
            own_q     <= 3'd0;
            grant     <= '0;
            sel       <= 3'b000;
            out_data  <= '0;
            out_valid <= 1'b0;
            ack       <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            grant     <= grant_d;
            sel       <= sel_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            ack       <= ack_d;
        end
    end

endmodule
